// File: rtl/rob_pkg.sv
// Shared constants and types for the ROB commit-side register file.
package rob_pkg;
  localparam int ROB_DEPTH  = 32;
  localparam int TAG_W      = 5;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     value;
    rob_tag_t              tag;
  } commit_t;
endpackage

// File: rtl/regfile_read_port.sv
// One operand lookup: stored value/busy/tag, with a bypass from the current commit.
module regfile_read_port
  import rob_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 5
) (
  input  logic [REG_ADDR_W-1:0]            addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              busy_vec,
  input  logic [NUM_REGS-1:0][TAG_W-1:0]   tags,
  input  logic                             commit_valid,
  input  logic                             commit_reg_write,
  input  logic [REG_ADDR_W-1:0]            commit_dest,
  input  logic [DATA_W-1:0]                commit_value,
  input  logic [TAG_W-1:0]                 commit_tag,
  output logic [DATA_W-1:0]                value,
  output logic                             busy,
  output logic [TAG_W-1:0]                 tag
);

  always_comb begin
    value = '0;
    busy  = 1'b0;
    tag   = '0;
    if (addr != '0) begin
      value = regs[addr];
      busy  = busy_vec[addr];
      tag   = tags[addr];
      // Only the producer the table is waiting for may resolve the operand.
      if (busy_vec[addr] && commit_valid && commit_reg_write &&
          commit_dest == addr && commit_tag == tags[addr]) begin
        value = commit_value;
        busy  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_commit_regfile.sv
// Architectural register file plus rename-tag table fed by the ROB retire stream.
module rob_commit_regfile
  import rob_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispatch_valid,
  input  logic              dispatch_reg_write,
  input  logic [4:0]        dispatch_rd,
  input  logic [TAG_W-1:0]  dispatch_tag,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_value,
  output logic              rs1_busy,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [DATA_W-1:0] rs2_value,
  output logic              rs2_busy,
  output logic [TAG_W-1:0]  rs2_tag,
  input  logic              commit_valid,
  input  logic              commit_reg_write,
  input  logic [4:0]        commit_dest,
  input  logic [DATA_W-1:0] commit_value,
  input  logic [TAG_W-1:0]  commit_tag,
  output logic [31:0]       retire_count
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;
  logic [NUM_REGS-1:0][TAG_W-1:0]  tags;

  commit_t cmt;
  logic    commit_wr;
  logic    dispatch_wr;

  assign cmt = '{valid:     commit_valid,
                 reg_write: commit_reg_write,
                 dest:      commit_dest,
                 value:     commit_value,
                 tag:       commit_tag};

  assign commit_wr   = cmt.valid && cmt.reg_write && (cmt.dest != '0);
  assign dispatch_wr = dispatch_valid && dispatch_reg_write && (dispatch_rd != '0) && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs         <= '0;
      busy         <= '0;
      tags         <= '0;
      retire_count <= '0;
    end else begin
      if (cmt.valid) retire_count <= retire_count + 32'd1;
      if (commit_wr) regs[cmt.dest] <= cmt.value;
      if (flush) begin
        busy <= '0;
      end else begin
        if (commit_wr && tags[cmt.dest] == cmt.tag) busy[cmt.dest] <= 1'b0;
        // Later assignment wins: a new mapping overrides the commit clear.
        if (dispatch_wr) begin
          busy[dispatch_rd] <= 1'b1;
          tags[dispatch_rd] <= dispatch_tag;
        end
      end
    end
  end

  regfile_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_rs1 (
    .addr             (rs1_addr),
    .regs             (regs),
    .busy_vec         (busy),
    .tags             (tags),
    .commit_valid     (cmt.valid),
    .commit_reg_write (cmt.reg_write),
    .commit_dest      (cmt.dest),
    .commit_value     (cmt.value),
    .commit_tag       (cmt.tag),
    .value            (rs1_value),
    .busy             (rs1_busy),
    .tag              (rs1_tag)
  );

  regfile_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_rs2 (
    .addr             (rs2_addr),
    .regs             (regs),
    .busy_vec         (busy),
    .tags             (tags),
    .commit_valid     (cmt.valid),
    .commit_reg_write (cmt.reg_write),
    .commit_dest      (cmt.dest),
    .commit_value     (cmt.value),
    .commit_tag       (cmt.tag),
    .value            (rs2_value),
    .busy             (rs2_busy),
    .tag              (rs2_tag)
  );

endmodule
